// File: rtl/mem_port_arb.sv
// Shares one single-port memory between instruction fetch and the load/store unit.
// Define ARB_FAIR_EN to force a fetch grant after STARVE_MAX data grants while fetch waits.
module mem_port_arb #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [3:0]        dm_be,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              Stall_IF,
    output logic              Stall_MEM
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic                r_memWe;
    logic [3:0]          r_memBe;
    logic [ADDR_W-1:0]   r_memAddr;
    logic [DATA_W-1:0]   r_memWdata;
    logic                w_grantI;
    logic                w_grantD;
    logic                w_forceFetch;
    logic                w_memDone;

`ifdef ARB_FAIR_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    logic [CNT_W-1:0] r_starve;

    assign w_forceFetch = if_req && (r_starve == CNT_W'(STARVE_MAX));

    // Counts data grants that overtook a waiting fetch; saturates at STARVE_MAX.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
        end else if (w_grantI) begin
            r_starve <= '0;
        end else if (w_grantD && if_req && (r_starve != CNT_W'(STARVE_MAX))) begin
            r_starve <= r_starve + 1'b1;
        end
    end
`else
    assign w_forceFetch = 1'b0;
`endif

    always_comb begin
        w_nextState = r_state;
        w_grantI    = 1'b0;
        w_grantD    = 1'b0;
        case (r_state)
            IDLE: begin
                if (dm_req && !w_forceFetch) begin
                    w_grantD    = 1'b1;
                    w_nextState = BUSY_D;
                end else if (if_req) begin
                    w_grantI    = 1'b1;
                    w_nextState = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Request fields are captured once at grant so the memory sees them stable until ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_memWe    <= 1'b0;
            r_memBe    <= 4'h0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_grantD) begin
                r_memWe    <= dm_we;
                r_memBe    <= dm_be;
                r_memAddr  <= dm_addr;
                r_memWdata <= dm_wdata;
            end else if (w_grantI) begin
                r_memWe    <= 1'b0;
                r_memBe    <= 4'hF;
                r_memAddr  <= if_addr;
                r_memWdata <= '0;
            end
        end
    end

    assign mem_req   = (r_state != IDLE);
    assign mem_we    = r_memWe;
    assign mem_be    = r_memBe;
    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;

    assign w_memDone = mem_ack && !rst;
    assign if_ack    = w_memDone && (r_state == BUSY_I);
    assign dm_ack    = w_memDone && (r_state == BUSY_D);
    assign if_rdata  = if_ack ? mem_rdata : '0;
    assign dm_rdata  = dm_ack ? mem_rdata : '0;

    assign Stall_IF  = if_req && !if_ack;
    assign Stall_MEM = dm_req && !dm_ack;

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb with a transaction-level reference model checked every cycle.
// Fairness expectations follow the ARB_FAIR_EN build setting.
module tb_mem_port_arb;

    localparam int STARVE_MAX = 4;
`ifdef ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        Stall_IF;
    logic        Stall_MEM;

    int errorCount = 0;
    int checkCount = 0;

    mem_port_arb #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .Stall_IF(Stall_IF), .Stall_MEM(Stall_MEM)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Sets every requester/memory input, then waits until combinational outputs have settled.
    task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr,
                                 input logic dmReq, input logic dmWe, input logic [3:0] dmBe,
                                 input logic [31:0] dmAddr, input logic [31:0] dmWdata,
                                 input logic memAck, input logic [31:0] memRdata);
        if_req    = ifReq;
        if_addr   = ifAddr;
        dm_req    = dmReq;
        dm_we     = dmWe;
        dm_be     = dmBe;
        dm_addr   = dmAddr;
        dm_wdata  = dmWdata;
        mem_ack   = memAck;
        mem_rdata = memRdata;
        #3;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: which access owns the memory and what it asked for.
    int          mOwner = 0;
    logic [31:0] mAddr  = '0;
    logic        mWe    = 1'b0;
    logic [3:0]  mBe    = '0;
    logic [31:0] mWdata = '0;
    int          mStarve = 0;
    bit          started = 1'b0;
    wire         mForced = FAIR && if_req && (mStarve >= STARVE_MAX);

    always @(posedge clk) begin
        started <= 1'b1;
        if (rst) begin
            mOwner  <= 0;
            mStarve <= 0;
        end else if (mOwner != 0) begin
            if (mem_ack) mOwner <= 0;
        end else if (dm_req && !mForced) begin
            mOwner <= 2;
            mAddr  <= dm_addr;
            mWe    <= dm_we;
            mBe    <= dm_be;
            mWdata <= dm_wdata;
            if (if_req) mStarve <= (mStarve + 1 > STARVE_MAX) ? STARVE_MAX : mStarve + 1;
        end else if (if_req) begin
            mOwner  <= 1;
            mAddr   <= if_addr;
            mWe     <= 1'b0;
            mBe     <= 4'hF;
            mStarve <= 0;
        end
    end

    logic expIfAck;
    logic expDmAck;

    always @(negedge clk) begin
        if (started) begin
            expIfAck = mem_ack && !rst && (mOwner == 1);
            expDmAck = mem_ack && !rst && (mOwner == 2);
            checkOutput("cmpMemReq", {31'b0, mem_req}, {31'b0, mOwner != 0});
            checkOutput("cmpIfAck", {31'b0, if_ack}, {31'b0, expIfAck});
            checkOutput("cmpDmAck", {31'b0, dm_ack}, {31'b0, expDmAck});
            checkOutput("cmpIfRdata", if_rdata, expIfAck ? mem_rdata : 32'h0);
            checkOutput("cmpDmRdata", dm_rdata, expDmAck ? mem_rdata : 32'h0);
            checkOutput("cmpStallIf", {31'b0, Stall_IF}, {31'b0, if_req && !expIfAck});
            checkOutput("cmpStallMem", {31'b0, Stall_MEM}, {31'b0, dm_req && !expDmAck});
            if (mOwner != 0) begin
                checkOutput("cmpMemAddr", mem_addr, mAddr);
                checkOutput("cmpMemWe", {31'b0, mem_we}, {31'b0, mWe});
                checkOutput("cmpMemBe", {28'b0, mem_be}, {28'b0, mBe});
                if (mOwner == 2) checkOutput("cmpMemWdata", mem_wdata, mWdata);
            end
        end
    end

    int ifAckCount;
    int dmAckCount;

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();

        // Still in reset: registers cleared, stall follows request, ack suppressed.
        applyStimulus(1, 32'h0, 0, 0, 0, 0, 0, 1, 32'h1234);
        checkOutput("rstMemReq", {31'b0, mem_req}, 32'h0);
        checkOutput("rstMemWe", {31'b0, mem_we}, 32'h0);
        checkOutput("rstMemBe", {28'b0, mem_be}, 32'h0);
        checkOutput("rstMemAddr", mem_addr, 32'h0);
        checkOutput("rstMemWdata", mem_wdata, 32'h0);
        checkOutput("rstIfAck", {31'b0, if_ack}, 32'h0);
        checkOutput("rstStallIf", {31'b0, Stall_IF}, 32'h1);
        tick();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Single zero-wait fetch.
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("fetchStallT", {31'b0, Stall_IF}, 32'h1);
        checkOutput("fetchIdleReq", {31'b0, mem_req}, 32'h0);
        tick();
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
        checkOutput("fetchMemReq", {31'b0, mem_req}, 32'h1);
        checkOutput("fetchMemAddr", mem_addr, 32'h100);
        checkOutput("fetchMemWe", {31'b0, mem_we}, 32'h0);
        checkOutput("fetchIfAck", {31'b0, if_ack}, 32'h1);
        checkOutput("fetchIfRdata", if_rdata, 32'hDEADBEEF);
        checkOutput("fetchDmRdata", dm_rdata, 32'h0);
        checkOutput("fetchStallT1", {31'b0, Stall_IF}, 32'h0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Store with three wait cycles.
        applyStimulus(0, 0, 1, 1, 4'b0011, 32'h2000, 32'h55, 0, 0);
        tick();
        for (int w = 0; w < 3; w++) begin
            applyStimulus(0, 0, 1, 1, 4'b0011, 32'h2000, 32'h55, 0, 0);
            checkOutput("storeMemReq", {31'b0, mem_req}, 32'h1);
            checkOutput("storeMemAddr", mem_addr, 32'h2000);
            checkOutput("storeMemWdata", mem_wdata, 32'h55);
            checkOutput("storeMemBe", {28'b0, mem_be}, 32'h3);
            checkOutput("storeMemWe", {31'b0, mem_we}, 32'h1);
            checkOutput("storeDmAckLow", {31'b0, dm_ack}, 32'h0);
            checkOutput("storeStallMem", {31'b0, Stall_MEM}, 32'h1);
            tick();
        end
        applyStimulus(0, 0, 1, 1, 4'b0011, 32'h2000, 32'h55, 1, 32'h0);
        checkOutput("storeDmAck", {31'b0, dm_ack}, 32'h1);
        checkOutput("storeStallDone", {31'b0, Stall_MEM}, 32'h0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("storeAckPulse", {31'b0, dm_ack}, 32'h0);
        tick();

        // Collision: data first, fetch granted after the bubble.
        applyStimulus(1, 32'h300, 1, 0, 4'hF, 32'h400, 0, 0, 0);
        tick();
        applyStimulus(1, 32'h300, 1, 0, 4'hF, 32'h400, 0, 1, 32'h11111111);
        checkOutput("collDmAck", {31'b0, dm_ack}, 32'h1);
        checkOutput("collDmRdata", dm_rdata, 32'h11111111);
        checkOutput("collIfAck", {31'b0, if_ack}, 32'h0);
        checkOutput("collMemAddr", mem_addr, 32'h400);
        checkOutput("collStallIf", {31'b0, Stall_IF}, 32'h1);
        tick();
        applyStimulus(1, 32'h300, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("collBubble", {31'b0, mem_req}, 32'h0);
        tick();
        applyStimulus(1, 32'h300, 0, 0, 0, 0, 0, 1, 32'h22222222);
        checkOutput("collFetchReq", {31'b0, mem_req}, 32'h1);
        checkOutput("collFetchAddr", mem_addr, 32'h300);
        checkOutput("collFetchAck", {31'b0, if_ack}, 32'h1);
        checkOutput("collFetchRdata", if_rdata, 32'h22222222);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Both requesters held with a memory that always acks.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(1, 32'h500, 1, 0, 4'hF, 32'h600, 0, 1, 32'hCAFE);
        tick();
        ifAckCount = 0;
        dmAckCount = 0;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1, 32'h500, 1, 0, 4'hF, 32'h600, 0, 1, 32'hCAFE);
            if (if_ack) ifAckCount++;
            if (dm_ack) dmAckCount++;
            tick();
        end
`ifdef ARB_FAIR_EN
        checkOutput("fairIfGrants", ifAckCount, 32'd2);
        checkOutput("fairDmGrants", dmAckCount, 32'd8);
`else
        checkOutput("fixedIfGrants", ifAckCount, 32'd0);
        checkOutput("fixedDmGrants", dmAckCount, 32'd10);
`endif
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Reset in the middle of a store, then a late memory ack.
        applyStimulus(0, 0, 1, 1, 4'hF, 32'h3000, 32'hAA, 0, 0);
        tick();
        applyStimulus(0, 0, 1, 1, 4'hF, 32'h3000, 32'hAA, 0, 0);
        checkOutput("midBusy", {31'b0, mem_req}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h77);
        checkOutput("midReqDropped", {31'b0, mem_req}, 32'h0);
        checkOutput("midLateDmAck", {31'b0, dm_ack}, 32'h0);
        checkOutput("midLateIfAck", {31'b0, if_ack}, 32'h0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("midStillIdle", {31'b0, mem_req}, 32'h0);
        tick();

        // Stray ack with nothing outstanding.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF);
        checkOutput("strayIfAck", {31'b0, if_ack}, 32'h0);
        checkOutput("strayDmAck", {31'b0, dm_ack}, 32'h0);
        checkOutput("strayDmRdata", dm_rdata, 32'h0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("strayIdle", {31'b0, mem_req}, 32'h0);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
